// File: rtl/argmax_classifier.sv
// Walks every aggregated node row, takes the argmax of its three class scores and stores a 2-bit label per node.
// Optional build macro ARGMAX_RELU_EN: signed scores with negatives clamped to 0 before the compare.
module argmax_classifier #(
    parameter int NUM_NODES = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 done_comb,
    input  logic [15:0]          adj_fm_wm_row [0:2],
    output logic [2:0]           read_row,
    output logic [1:0]           class_out [0:NUM_NODES-1],
    output logic [NUM_NODES-1:0] label_valid,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [2:0] LAST_NODE = 3'(NUM_NODES - 1);

    state_t      state;
    state_t      state_next;
    logic [2:0]  node;
    logic [15:0] score [0:2];
    logic [15:0] best_val;
    logic [1:0]  best_idx;

    function automatic logic [15:0] rank(input logic [15:0] s);
`ifdef ARGMAX_RELU_EN
        // Once negatives are clamped, the remaining values are non-negative, so an unsigned compare is exact.
        return s[15] ? '0 : s;
`else
        return s;
`endif
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (done_comb) state_next = S_FETCH;
            S_FETCH:   state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_WRITE;
            S_WRITE:   state_next = (node == LAST_NODE) ? S_DONE : S_FETCH;
            S_DONE:    state_next = S_DONE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Strict greater-than while scanning upward keeps ties on the lowest index.
    always_comb begin
        best_val = rank(score[0]);
        best_idx = 2'd0;
        if (rank(score[1]) > best_val) begin
            best_val = rank(score[1]);
            best_idx = 2'd1;
        end
        if (rank(score[2]) > best_val) begin
            best_val = rank(score[2]);
            best_idx = 2'd2;
        end
    end

    always_comb begin
        read_row = (state == S_IDLE) ? '0 : node;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            node        <= '0;
            label_valid <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            for (int unsigned k = 0; k < 3; k++) begin
                score[k] <= '0;
            end
            for (int unsigned n = 0; n < NUM_NODES; n++) begin
                class_out[n] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (done_comb) begin
                        node <= '0;
                        busy <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    // Address is still held here, so both combinational and 1-cycle registered reads are valid.
                    for (int unsigned k = 0; k < 3; k++) begin
                        score[k] <= adj_fm_wm_row[k];
                    end
                end
                S_WRITE: begin
                    for (int unsigned n = 0; n < NUM_NODES; n++) begin
                        if (node == 3'(n)) begin
                            class_out[n]   <= best_idx;
                            label_valid[n] <= 1'b1;
                        end
                    end
                    if (node == LAST_NODE) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        node <= node + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench: stimulus pushes expected labels, a negedge monitor pops them as label_valid bits rise.
module tb_argmax_classifier;

    typedef struct {
        int node;
        int label;
        int due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1, start_a_sig = 1'b0;
    logic        rst_b = 1'b1, start_b_sig = 1'b0;
    logic [15:0] mem_a [0:7][0:2];
    logic [15:0] mem_b [0:7][0:2];
    logic [15:0] rd_a [0:2];
    logic [15:0] rd_b [0:2];
    logic [2:0]  rr_a, rr_b;
    logic [1:0]  cls_a [0:5];
    logic [1:0]  cls_b [0:7];
    logic [5:0]  lv_a;
    logic [7:0]  lv_b;
    logic        busy_a, done_a, busy_b, done_b;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   e0_a, done_due_a;
    exp_t expq [$];
    int   rr_log [$];
    logic [5:0] prev_lv = '0;
    logic       prev_done = 1'b0;

    argmax_classifier #(.NUM_NODES(6)) dut_a (
        .clk(clk), .rst(rst_a), .done_comb(start_a_sig), .adj_fm_wm_row(rd_a),
        .read_row(rr_a), .class_out(cls_a), .label_valid(lv_a), .busy(busy_a), .done(done_a)
    );

    argmax_classifier #(.NUM_NODES(8)) dut_b (
        .clk(clk), .rst(rst_b), .done_comb(start_b_sig), .adj_fm_wm_row(rd_b),
        .read_row(rr_b), .class_out(cls_b), .label_valid(lv_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 1-cycle registered memories
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            rd_a[k] <= mem_a[rr_a][k];
            rd_b[k] <= mem_b[rr_b][k];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int score_val(input logic [15:0] s);
`ifdef ARGMAX_RELU_EN
        int v;
        v = int'($signed(s));
        return (v < 0) ? 0 : v;
`else
        return int'(s);
`endif
    endfunction

    // First index holding the maximum score.
    function automatic int model_label(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        int v [3];
        int mx;
        v[0] = score_val(a);
        v[1] = score_val(b);
        v[2] = score_val(c);
        mx = v[0];
        for (int i = 1; i < 3; i++) if (v[i] > mx) mx = v[i];
        for (int i = 0; i < 3; i++) if (v[i] == mx) return i;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (!rst_a) begin
            for (int n = 0; n < 6; n++) begin
                if (lv_a[n] && !prev_lv[n]) begin
                    if (expq.size() == 0) begin
                        check("unexpected_label", n, -1);
                    end else begin
                        exp_t it;
                        it = expq.pop_front();
                        check("label_node", n, it.node);
                        check("label_value", int'(cls_a[n]), it.label);
                        check("label_cycle", cyc, it.due);
                        check("busy_at_label", int'(busy_a), (n != 5) ? 1 : 0);
                    end
                end
            end
            if (done_a && !prev_done) begin
                check("done_cycle", cyc, done_due_a);
                check("busy_at_done", int'(busy_a), 0);
            end
            if (busy_a && (rr_log.size() == 0 || rr_log[$] != int'(rr_a))) rr_log.push_back(int'(rr_a));
        end
        prev_lv   = lv_a;
        prev_done = done_a;
    end

    task automatic set_row_a(input int n, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        mem_a[n][0] = a;
        mem_a[n][1] = b;
        mem_a[n][2] = c;
    endtask

    function automatic logic [15:0] rand_score();
        case ($urandom_range(0, 2))
            0: return 16'($urandom_range(0, 3));
            1: return 16'($urandom);
            default: begin
                case ($urandom_range(0, 3))
                    0: return 16'h0000;
                    1: return 16'h7FFF;
                    2: return 16'h8000;
                    default: return 16'hFFFF;
                endcase
            end
        endcase
    endfunction

    task automatic reset_a();
        @(negedge clk); #2;
        rst_a = 1'b1;
        start_a_sig = 1'b0;
        @(negedge clk); #2;
        rst_a = 1'b0;
        expq.delete();
        rr_log.delete();
    endtask

    task automatic start_a();
        @(negedge clk); #2;
        expq.delete();
        rr_log.delete();
        e0_a = cyc + 1;
        for (int n = 0; n < 6; n++) begin
            exp_t it;
            it.node  = n;
            it.label = model_label(mem_a[n][0], mem_a[n][1], mem_a[n][2]);
            it.due   = e0_a + 3 * (n + 1);
            expq.push_back(it);
        end
        done_due_a = e0_a + 18;
        start_a_sig = 1'b1;
        @(negedge clk); #2;
        start_a_sig = 1'b0;
    endtask

    task automatic wait_done_a(input bit toggle);
        for (int i = 0; i < 100 && !done_a; i++) begin
            @(negedge clk); #2;
            if (toggle) start_a_sig = 1'($urandom_range(0, 1));
        end
        check("done_reached", int'(done_a), 1);
    endtask

    task automatic check_final_a();
        for (int n = 0; n < 6; n++)
            check("final_label", int'(cls_a[n]), model_label(mem_a[n][0], mem_a[n][1], mem_a[n][2]));
        check("final_valid", int'(lv_a), 6'h3F);
        check("final_done", int'(done_a), 1);
        check("final_busy", int'(busy_a), 0);
        check("final_read_row", int'(rr_a), 5);
        check("queue_drained", expq.size(), 0);
        check("addr_count", rr_log.size(), 6);
        for (int n = 0; n < rr_log.size() && n < 6; n++) check("addr_seq", rr_log[n], n);
    endtask

    initial begin
        for (int n = 0; n < 8; n++)
            for (int k = 0; k < 3; k++) begin
                mem_a[n][k] = '0;
                mem_b[n][k] = '0;
            end

        // Reset values
        repeat (3) @(negedge clk);
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk); #2;
        check("rst_read_row", int'(rr_a), 0);
        check("rst_valid", int'(lv_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        for (int n = 0; n < 6; n++) check("rst_class", int'(cls_a[n]), 0);

        // Basic run with done_comb toggled during and after the run
        set_row_a(0, 5, 9, 2);
        set_row_a(1, 7, 1, 1);
        set_row_a(2, 0, 0, 8);
        set_row_a(3, 3, 3, 1);
        set_row_a(4, 4, 4, 4);
        set_row_a(5, 1, 2, 3);
        start_a();
        wait_done_a(1'b1);
        check_final_a();
        repeat (12) begin
            @(negedge clk); #2;
            start_a_sig = ~start_a_sig;
        end
        start_a_sig = 1'b0;
        check("post_done_no_restart", int'(busy_a), 0);
        check_final_a();

        // Reset asserted during FETCH of node 2
        reset_a();
        for (int n = 0; n < 6; n++) set_row_a(n, rand_score(), rand_score(), rand_score());
        start_a();
        for (int i = 0; i < 20 && cyc < e0_a + 6; i++) @(negedge clk);
        #2;
        check("pre_rst_read_row", int'(rr_a), 2);
        check("pre_rst_valid", int'(lv_a), 6'h03);
        rst_a = 1'b1;
        #1;
        check("mid_rst_read_row", int'(rr_a), 0);
        check("mid_rst_valid", int'(lv_a), 0);
        check("mid_rst_busy", int'(busy_a), 0);
        for (int n = 0; n < 6; n++) check("mid_rst_class", int'(cls_a[n]), 0);
        @(negedge clk); #2;
        rst_a = 1'b0;
        expq.delete();
        rr_log.delete();
        repeat (5) @(negedge clk);
        #2;
        check("idle_after_rst_busy", int'(busy_a), 0);
        check("idle_after_rst_done", int'(done_a), 0);
        check("idle_after_rst_addr", int'(rr_a), 0);

        // Randomized runs; the first one carries the clamping probe row
        for (int r = 0; r < 5; r++) begin
            reset_a();
            for (int n = 0; n < 6; n++) set_row_a(n, rand_score(), rand_score(), rand_score());
            if (r == 0) set_row_a(0, 16'hFFF0, 16'h0000, 16'hFFFF);
            start_a();
            wait_done_a(r[0]);
            check_final_a();
        end

        // Eight-node instance: counter reaches 7 without wrapping
        begin
            int e0_b;
            for (int n = 0; n < 8; n++) begin
                mem_b[n][0] = 16'h0000;
                mem_b[n][1] = 16'h0000;
                mem_b[n][2] = 16'h8000;
            end
            @(negedge clk); #2;
            e0_b = cyc + 1;
            start_b_sig = 1'b1;
            @(negedge clk); #2;
            start_b_sig = 1'b0;
            for (int i = 0; i < 100 && !done_b; i++) @(negedge clk);
            check("b_done_cycle", cyc, e0_b + 24);
            check("b_valid", int'(lv_b), 8'hFF);
            check("b_busy", int'(busy_b), 0);
            check("b_read_row", int'(rr_b), 7);
            for (int n = 0; n < 8; n++)
                check("b_label", int'(cls_b[n]), model_label(mem_b[n][0], mem_b[n][1], mem_b[n][2]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
